// File: rtl/uart_frame_pkg.sv
// ----------------------------------------------------------------------------
// uart_frame_pkg
// Shared definitions for the framed UART link:
//   - SYNC_DEFAULT : default frame header byte
//   - tx_state_t   : transmit framer states (IDLE, LOAD, WAIT)
//   - rx_state_t   : receive deframer states (HUNT, SEQ, DATA, CHK)
//   - idx_width()  : width of a byte index spanning a whole frame
// ----------------------------------------------------------------------------
package uart_frame_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HUNT = 2'd0,
        RX_SEQ  = 2'd1,
        RX_DATA = 2'd2,
        RX_CHK  = 2'd3
    } rx_state_t;

    // A frame is SYNC + SEQ + N_BYTES payload + CHK.
    function automatic int idx_width(input int n_bytes);
        return $clog2(n_bytes + 3);
    endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// ----------------------------------------------------------------------------
// uart_frame_rx
// Receive deframer. Hunts for the SYNC byte, collects SEQ and the payload
// into a shadow register, and publishes them only when the XOR checksum
// matches. Bad checksums and inter-byte timeouts bump a saturating error
// counter. Also tracks link health from the stream of good frames.
//
// Ports:
//   clk, reset     : system clock, asynchronous active-high reset
//   rx_byte        : byte from the byte-level UART receiver
//   rx_done_tick   : rx_byte valid this cycle
//   rx_payload     : last good payload (byte k at [8k+7:8k])
//   rx_valid       : one-cycle pulse per good frame
//   rx_seq         : sequence number of the last good frame
//   rx_err_cnt     : saturating count of bad checksums and timeouts
//   link_up        : a good frame arrived within LINK_TIMEOUT cycles
// ----------------------------------------------------------------------------
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         N_BYTES       = 8,
    parameter logic [7:0] SYNC          = SYNC_DEFAULT,
    parameter int         TIMEOUT_TICKS = 4096,
    parameter int         LINK_TIMEOUT  = 2**22
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_done_tick,
    output logic [8*N_BYTES-1:0]   rx_payload,
    output logic                   rx_valid,
    output logic [7:0]             rx_seq,
    output logic [7:0]             rx_err_cnt,
    output logic                   link_up
);

    localparam int IDX_W  = idx_width(N_BYTES);
    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam int LINK_W = $clog2(LINK_TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(N_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [LINK_W-1:0] LINK_LAST = LINK_W'(LINK_TIMEOUT - 1);

    rx_state_t              state;
    logic [IDX_W-1:0]       idx;
    logic [8*N_BYTES-1:0]   shadow;
    logic [7:0]             seq_shadow;
    logic [7:0]             chk_acc;
    logic [TO_W-1:0]        to_cnt;
    logic [LINK_W-1:0]      link_cnt;
    logic                   timeout;
    logic                   frame_good;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // A byte arriving on the last allowed cycle wins over the timeout.
    assign timeout    = (state != RX_HUNT) && !rx_done_tick && (to_cnt == TO_LAST);
    assign frame_good = (state == RX_CHK) && rx_done_tick && (rx_byte == chk_acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RX_HUNT;
            idx        <= '0;
            shadow     <= '0;
            seq_shadow <= '0;
            chk_acc    <= '0;
            to_cnt     <= '0;
            rx_payload <= '0;
            rx_seq     <= '0;
            rx_valid   <= 1'b0;
            rx_err_cnt <= '0;
        end else begin
            rx_valid <= 1'b0;

            if (state == RX_HUNT || rx_done_tick) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (timeout) begin
                state      <= RX_HUNT;
                rx_err_cnt <= sat_inc(rx_err_cnt);
            end else if (rx_done_tick) begin
                case (state)
                    RX_HUNT: begin
                        if (rx_byte == SYNC) begin
                            state <= RX_SEQ;
                        end
                    end
                    RX_SEQ: begin
                        seq_shadow <= rx_byte;
                        chk_acc    <= rx_byte;
                        idx        <= '0;
                        state      <= RX_DATA;
                    end
                    RX_DATA: begin
                        // SYNC values are ordinary payload here.
                        for (int k = 0; k < N_BYTES; k++) begin
                            if (idx == IDX_W'(k)) begin
                                shadow[8*k +: 8] <= rx_byte;
                            end
                        end
                        chk_acc <= chk_acc ^ rx_byte;
                        idx     <= idx + IDX_W'(1);
                        if (idx == LAST_DATA) begin
                            state <= RX_CHK;
                        end
                    end
                    RX_CHK: begin
                        if (rx_byte == chk_acc) begin
                            rx_payload <= shadow;
                            rx_seq     <= seq_shadow;
                            rx_valid   <= 1'b1;
                        end else begin
                            rx_err_cnt <= sat_inc(rx_err_cnt);
                        end
                        state <= RX_HUNT;
                    end
                    default: state <= RX_HUNT;
                endcase
            end
        end
    end

    // link_up rises together with rx_valid and falls after LINK_TIMEOUT
    // cycles without another good frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_up  <= 1'b0;
            link_cnt <= '0;
        end else if (frame_good) begin
            link_up  <= 1'b1;
            link_cnt <= '0;
        end else if (link_up) begin
            if (link_cnt == LINK_LAST) begin
                link_up  <= 1'b0;
                link_cnt <= '0;
            end else begin
                link_cnt <= link_cnt + LINK_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_frame_link.sv
// ----------------------------------------------------------------------------
// uart_frame_link
// Framed link on top of a byte-level UART. The transmit framer (inline)
// sends SYNC, SEQ, payload bytes 0..N_BYTES-1 and an XOR checksum, one
// byte per tx_start/tx_done_tick handshake. The receive deframer lives in
// uart_frame_rx. Both directions run independently.
//
// Ports:
//   clk, reset     : system clock, asynchronous active-high reset
//   tx_payload     : payload to send (byte k at [8k+7:8k])
//   tx_req         : request one frame (ignored while tx_busy)
//   tx_busy        : transmit frame in progress
//   tx_byte        : byte to the byte transmitter
//   tx_start       : one-cycle start pulse to the byte transmitter
//   tx_done_tick   : byte transmitter finished the current byte
//   rx_byte        : byte from the byte receiver
//   rx_done_tick   : rx_byte valid this cycle
//   rx_payload     : last good received payload
//   rx_valid       : one-cycle pulse per good frame
//   rx_seq         : sequence number of the last good frame
//   rx_err_cnt     : saturating receive error counter
//   link_up        : a good frame arrived within LINK_TIMEOUT cycles
// ----------------------------------------------------------------------------
module uart_frame_link
    import uart_frame_pkg::*;
#(
    parameter int         N_BYTES       = 8,
    parameter logic [7:0] SYNC          = SYNC_DEFAULT,
    parameter int         TIMEOUT_TICKS = 4096,
    parameter int         LINK_TIMEOUT  = 2**22
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*N_BYTES-1:0]   tx_payload,
    input  logic                   tx_req,
    output logic                   tx_busy,
    output logic [7:0]             tx_byte,
    output logic                   tx_start,
    input  logic                   tx_done_tick,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_done_tick,
    output logic [8*N_BYTES-1:0]   rx_payload,
    output logic                   rx_valid,
    output logic [7:0]             rx_seq,
    output logic [7:0]             rx_err_cnt,
    output logic                   link_up
);

    localparam int               IDX_W    = idx_width(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES + 2);

    tx_state_t             tx_state;
    logic [IDX_W-1:0]      tx_idx;
    logic [IDX_W-1:0]      next_idx;
    logic [8*N_BYTES-1:0]  tx_buf;
    logic [7:0]            tx_seq;
    logic [7:0]            tx_chk;
    logic [7:0]            next_byte;

    function automatic logic [7:0] xor_bytes(input logic [8*N_BYTES-1:0] p);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < N_BYTES; k++) begin
            acc = acc ^ p[8*k +: 8];
        end
        return acc;
    endfunction

    assign next_idx = tx_idx + IDX_W'(1);

    // Byte that follows the one currently on the wire. Index 0 (SYNC) is
    // only ever loaded straight from IDLE, so it never appears here.
    always_comb begin
        next_byte = tx_chk;
        if (next_idx == IDX_W'(1)) begin
            next_byte = tx_seq;
        end
        for (int k = 0; k < N_BYTES; k++) begin
            if (next_idx == IDX_W'(k + 2)) begin
                next_byte = tx_buf[8*k +: 8];
            end
        end
    end

    // Payload and checksum are captured at request time so the caller may
    // change tx_payload freely during the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_idx   <= '0;
            tx_buf   <= '0;
            tx_seq   <= '0;
            tx_chk   <= '0;
            tx_byte  <= '0;
            tx_start <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_req) begin
                        tx_buf   <= tx_payload;
                        tx_chk   <= tx_seq ^ xor_bytes(tx_payload);
                        tx_idx   <= '0;
                        tx_byte  <= SYNC;
                        tx_start <= 1'b1;
                        tx_busy  <= 1'b1;
                        tx_state <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done_tick) begin
                        if (tx_idx == LAST_IDX) begin
                            tx_seq   <= tx_seq + 8'd1;
                            tx_busy  <= 1'b0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_idx   <= next_idx;
                            tx_byte  <= next_byte;
                            tx_start <= 1'b1;
                            tx_state <= TX_LOAD;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_frame_rx #(
        .N_BYTES       (N_BYTES),
        .SYNC          (SYNC),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .LINK_TIMEOUT  (LINK_TIMEOUT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_done_tick (rx_done_tick),
        .rx_payload   (rx_payload),
        .rx_valid     (rx_valid),
        .rx_seq       (rx_seq),
        .rx_err_cnt   (rx_err_cnt),
        .link_up      (link_up)
    );

endmodule

// File: tb/tb_uart_frame_link.sv
// ----------------------------------------------------------------------------
// tb_uart_frame_link
// Scoreboard bench: stimulus pushes expected TX bytes and expected RX frames
// into queues; a TX responder (acting as the byte transmitter) and an RX
// monitor pop and compare whenever the DUT presents tx_start / rx_valid.
// ----------------------------------------------------------------------------
module tb_uart_frame_link;

    localparam int         N   = 4;
    localparam int         TO  = 64;
    localparam int         LT  = 300;
    localparam logic [7:0] SY  = 8'hA5;
    localparam int         FW  = 8 * (N + 3);

    typedef struct packed {
        logic [7:0]  seq;
        logic [31:0] pl;
    } rxexp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   tx_payload;
    logic          req_stim;
    logic          req_resp;
    logic          tx_req;
    logic          tx_busy;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_done_tick;
    logic [7:0]    rx_byte;
    logic          rx_done_tick;
    logic [31:0]   rx_payload;
    logic          rx_valid;
    logic [7:0]    rx_seq;
    logic [7:0]    rx_err_cnt;
    logic          link_up;

    assign tx_req = req_stim | req_resp;

    always #5 clk = ~clk;

    uart_frame_link #(
        .N_BYTES       (N),
        .SYNC          (SY),
        .TIMEOUT_TICKS (TO),
        .LINK_TIMEOUT  (LT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_payload   (tx_payload),
        .tx_req       (tx_req),
        .tx_busy      (tx_busy),
        .tx_byte      (tx_byte),
        .tx_start     (tx_start),
        .tx_done_tick (tx_done_tick),
        .rx_byte      (rx_byte),
        .rx_done_tick (rx_done_tick),
        .rx_payload   (rx_payload),
        .rx_valid     (rx_valid),
        .rx_seq       (rx_seq),
        .rx_err_cnt   (rx_err_cnt),
        .link_up      (link_up)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] txq[$];     // {last_byte_flag, byte}
    rxexp_t     rxq[$];

    // Reference model state
    logic [7:0]  m_tx_seq = 8'd0;
    logic [7:0]  m_err    = 8'd0;
    logic [31:0] m_pl     = 32'd0;
    logic [7:0]  m_seq    = 8'd0;
    int          start_cnt = 0;
    int          rst_epoch = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame per the link format: SYNC, SEQ, payload LSB byte first, XOR check.
    function automatic logic [FW-1:0] make_frame(input logic [7:0] seq, input logic [31:0] pl);
        logic [FW-1:0] f;
        logic [7:0]    c;
        f        = '0;
        f[7:0]   = SY;
        f[15:8]  = seq;
        c        = seq;
        for (int k = 0; k < N; k++) begin
            f[8*(k+2) +: 8] = pl[8*k +: 8];
            c               = c ^ pl[8*k +: 8];
        end
        f[FW-1 -: 8] = c;
        return f;
    endfunction

    function automatic logic [31:0] rand_pl();
        logic [31:0] p;
        for (int k = 0; k < N; k++) begin
            p[8*k +: 8] = ($urandom_range(0, 3) == 0) ? SY : 8'($urandom);
        end
        return p;
    endfunction

    function automatic logic [7:0] rand_junk();
        logic [7:0] j;
        j = 8'($urandom);
        if (j == SY) j = 8'h5A;
        return j;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_put(input logic [7:0] b);
        rx_byte      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        rx_byte      = 8'($urandom);
    endtask

    // Send a complete frame; long_at selects a byte preceded by the longest
    // legal gap (TO-1 idle cycles), -1 for none.
    task automatic rx_stream(input logic [FW-1:0] f, input int max_gap, input int long_at);
        logic [7:0] c;
        c = f[15:8];
        for (int k = 0; k < N; k++) c = c ^ f[8*(k+2) +: 8];
        if (c == f[FW-1 -: 8]) begin
            m_pl  = f[8*N+15:16];
            m_seq = f[15:8];
            rxq.push_back('{seq: m_seq, pl: m_pl});
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
        for (int i = 0; i < N + 3; i++) begin
            if (i == long_at) idle(TO - 1);
            else if (i != 0) idle($urandom_range(0, max_gap));
            rx_put(f[8*i +: 8]);
        end
        idle(2);
        check("rx_err_cnt", 64'(rx_err_cnt), 64'(m_err));
        check("rx_payload_held", 64'(rx_payload), 64'(m_pl));
        check("rx_seq_held", 64'(rx_seq), 64'(m_seq));
    endtask

    // Partial frame (SYNC plus 'extra' more bytes) then silence.
    task automatic rx_truncated(input logic [FW-1:0] f, input int extra);
        for (int i = 0; i <= extra; i++) rx_put(f[8*i +: 8]);
        idle(TO + 3);
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        check("rx_err_timeout", 64'(rx_err_cnt), 64'(m_err));
        check("rx_payload_timeout", 64'(rx_payload), 64'(m_pl));
    endtask

    task automatic tx_frame(input logic [31:0] pl);
        logic [FW-1:0] f;
        int            n;
        f = make_frame(m_tx_seq, pl);
        for (int i = 0; i < N + 3; i++) txq.push_back({(i == N + 2), f[8*i +: 8]});
        m_tx_seq   = m_tx_seq + 8'd1;
        tx_payload = pl;
        req_stim   = 1'b1;
        @(posedge clk);
        #1;
        req_stim   = 1'b0;
        tx_payload = $urandom;
        check("tx_busy_rise", 64'(tx_busy), 64'(1));
        idle(2);
        // Request while busy must be ignored.
        req_stim = 1'b1;
        @(posedge clk);
        #1;
        req_stim = 1'b0;
        n = 0;
        while (tx_busy === 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_busy_fall", 64'(tx_busy), 64'(0));
        check("tx_all_bytes_sent", 64'(txq.size()), 64'(0));
        idle(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rst_epoch++;
        idle(3);
        check("rst_tx_busy", 64'(tx_busy), 64'(0));
        check("rst_tx_start", 64'(tx_start), 64'(0));
        check("rst_tx_byte", 64'(tx_byte), 64'(0));
        check("rst_rx_payload", 64'(rx_payload), 64'(0));
        check("rst_rx_seq", 64'(rx_seq), 64'(0));
        check("rst_rx_valid", 64'(rx_valid), 64'(0));
        check("rst_rx_err_cnt", 64'(rx_err_cnt), 64'(0));
        check("rst_link_up", 64'(link_up), 64'(0));
        txq.delete();
        rxq.delete();
        m_tx_seq = 8'd0;
        m_err    = 8'd0;
        m_pl     = 32'd0;
        m_seq    = 8'd0;
        reset    = 1'b0;
        idle(2);
    endtask

    // Byte transmitter model and TX scoreboard.
    initial begin : tx_responder
        logic [8:0] e;
        logic [7:0] b;
        int         ep;
        tx_done_tick = 1'b0;
        req_resp     = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && reset !== 1'b1) begin
                start_cnt++;
                b  = tx_byte;
                ep = rst_epoch;
                if (txq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected_start actual=%0h required=no_start", b);
                end else begin
                    e = txq.pop_front();
                    check("tx_byte", 64'(b), 64'(e[7:0]));
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                    if (ep == rst_epoch && reset !== 1'b1) begin
                        check("tx_byte_hold", 64'(tx_byte), 64'(b));
                        tx_done_tick = 1'b1;
                        req_resp     = e[8];   // request coinciding with final done
                        @(posedge clk);
                        #1;
                        tx_done_tick = 1'b0;
                        req_resp     = 1'b0;
                        if (ep == rst_epoch)
                            check("tx_busy_after_done", 64'(tx_busy), 64'(!e[8]));
                    end
                end
            end
        end
    end

    initial begin : tx_pulse_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) check("tx_start_one_cycle", 64'(prev), 64'(0));
            prev = tx_start;
        end
    end

    initial begin : rx_monitor
        rxexp_t e;
        logic   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                check("rx_valid_one_cycle", 64'(prev), 64'(0));
                if (rxq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected_valid actual=%0h required=no_valid", rx_payload);
                end else begin
                    e = rxq.pop_front();
                    check("rx_payload", 64'(rx_payload), 64'(e.pl));
                    check("rx_seq", 64'(rx_seq), 64'(e.seq));
                    check("link_up_with_valid", 64'(link_up), 64'(1));
                end
            end
            prev = rx_valid;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        logic [FW-1:0] f;
        int            base;
        int            n;
        reset        = 1'b1;
        tx_payload   = '0;
        req_stim     = 1'b0;
        rx_byte      = '0;
        rx_done_tick = 1'b0;
        idle(1);
        do_reset();

        // Directed TX frame, then SEQ advances to 01.
        tx_frame(32'h11223344);
        tx_frame(rand_pl());

        // Good frame, bad checksum, junk before SYNC.
        f = make_frame(8'h07, 32'h11223344);
        rx_stream(f, 0, -1);
        check("link_up_after_good", 64'(link_up), 64'(1));
        f[FW-1 -: 8] = 8'h00;
        rx_stream(f, 0, -1);
        rx_put(8'h00);
        rx_put(8'hFF);
        rx_stream(make_frame(8'h08, 32'hA5A5_00A5), 1, -1);

        // Timeout mid-frame, then a good frame; longest legal gap accepted.
        rx_truncated(make_frame(8'h07, 32'h11223344), 2);
        rx_stream(make_frame(8'h09, 32'hCAFE_F00D), 0, -1);
        rx_stream(make_frame(8'h0A, 32'h0102_0304), 0, 4);

        // Randomized mix.
        for (int it = 0; it < 24; it++) begin
            f = make_frame(8'($urandom), rand_pl());
            case ($urandom_range(0, 3))
                0: rx_stream(f, 4, -1);
                1: begin
                    f[FW-1 -: 8] = f[FW-1 -: 8] ^ 8'(1 << $urandom_range(0, 7));
                    rx_stream(f, 4, -1);
                end
                2: begin
                    repeat ($urandom_range(1, 3)) rx_put(rand_junk());
                    rx_stream(f, 2, -1);
                end
                default: rx_truncated(f, $urandom_range(0, N + 1));
            endcase
        end

        // TX and RX concurrently.
        fork
            tx_frame(rand_pl());
            begin
                rx_stream(make_frame(8'($urandom), rand_pl()), 3, -1);
                rx_stream(make_frame(8'($urandom), rand_pl()), 3, -1);
            end
        join

        // Link timeout.
        rx_stream(make_frame(8'h33, rand_pl()), 0, -1);
        idle(250);
        check("link_up_hold", 64'(link_up), 64'(1));
        idle(60);
        check("link_up_drop", 64'(link_up), 64'(0));

        // Error counter saturation.
        for (int it = 0; it < 260; it++) begin
            f = make_frame(8'($urandom), rand_pl());
            f[FW-1 -: 8] = ~f[FW-1 -: 8];
            rx_stream(f, 0, -1);
        end
        check("rx_err_saturated", 64'(rx_err_cnt), 64'(8'hFF));

        // Reset after the third tx_start aborts the frame.
        base = start_cnt;
        f = make_frame(m_tx_seq, 32'hDEAD_BEEF);
        for (int i = 0; i < N + 3; i++) txq.push_back({(i == N + 2), f[8*i +: 8]});
        tx_payload = 32'hDEAD_BEEF;
        req_stim   = 1'b1;
        @(posedge clk);
        #1;
        req_stim = 1'b0;
        n = 0;
        while (start_cnt < base + 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tx_third_start_seen", 64'(start_cnt - base), 64'(3));
        do_reset();
        idle(30);
        check("tx_no_start_after_reset", 64'(start_cnt - base), 64'(3));
        tx_frame(32'h11223344);

        idle(5);
        check("rx_queue_drained", 64'(rxq.size()), 64'(0));
        check("tx_queue_drained", 64'(txq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
